// File: rtl/fusion_pkg.sv
// Shared types and helpers for the fusion column: psum lane modes, lane widths
// and collector FSM states.
package fusion_pkg;

    localparam int PSUM_W    = 52;
    localparam int LANE_W_8B = 52;
    localparam int LANE_W_4B = 26;
    localparam int LANE_W_2B = 13;

    typedef enum logic [1:0] {
        MODE_8B = 2'd0,
        MODE_4B = 2'd1,
        MODE_2B = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    function automatic logic [2:0] lanes_per_mode(input mode_e m);
        logic [2:0] n;
        case (m)
            MODE_8B: n = 3'd1;
            MODE_4B: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Width code priority: bit3 wins over bit2; 2b and 1b share one layout.
    function automatic mode_e decode_mode(input logic [3:0] ww);
        mode_e m;
        if (ww[3]) begin
            m = MODE_8B;
        end else if (ww[2]) begin
            m = MODE_4B;
        end else begin
            m = MODE_2B;
        end
        return m;
    endfunction

endpackage

// File: rtl/psum_lane_extract.sv
// Splits a packed psum beat into up to four lanes and extends each to the
// accumulator width; lanes the mode does not use are forced to zero.
module psum_lane_extract
    import fusion_pkg::*;
#(
    parameter int ACC_W = 64
) (
    input  logic [PSUM_W-1:0]     psum_data,
    input  mode_e                 mode,
    input  logic                  signed_mode,
    output logic [3:0][ACC_W-1:0] lanes
);

    function automatic logic [ACC_W-1:0] ext52(input logic [LANE_W_8B-1:0] v, input logic s);
        logic [ACC_W-1:0] r;
        if (s) begin
            r = ACC_W'($signed(v));
        end else begin
            r = ACC_W'(v);
        end
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] ext26(input logic [LANE_W_4B-1:0] v, input logic s);
        logic [ACC_W-1:0] r;
        if (s) begin
            r = ACC_W'($signed(v));
        end else begin
            r = ACC_W'(v);
        end
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] ext13(input logic [LANE_W_2B-1:0] v, input logic s);
        logic [ACC_W-1:0] r;
        if (s) begin
            r = ACC_W'($signed(v));
        end else begin
            r = ACC_W'(v);
        end
        return r;
    endfunction

    // Lane unpack and extension by mode
    always_comb begin
        lanes = '0;
        case (mode)
            MODE_8B: begin
                lanes[0] = ext52(psum_data[51:0], signed_mode);
            end
            MODE_4B: begin
                lanes[0] = ext26(psum_data[25:0], signed_mode);
                lanes[1] = ext26(psum_data[51:26], signed_mode);
            end
            MODE_2B: begin
                lanes[0] = ext13(psum_data[12:0], signed_mode);
                lanes[1] = ext13(psum_data[25:13], signed_mode);
                lanes[2] = ext13(psum_data[38:26], signed_mode);
                lanes[3] = ext13(psum_data[51:39], signed_mode);
            end
            default: begin
                lanes = '0;
            end
        endcase
    end

endmodule

// File: rtl/psum_collector.sv
// Collects packed partial sums from the fusion column, accumulates a group of
// passes per lane and drains the lane totals one per cycle downstream.
module psum_collector
    import fusion_pkg::*;
#(
    parameter int ACC_W      = 64,
    parameter int PASS_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psum_valid,
    output logic                  psum_ready,
    input  logic [PSUM_W-1:0]     psum_data,
    input  logic [3:0]            weight_width,
    input  logic                  signed_mode,
    input  logic [PASS_CNT_W-1:0] num_passes,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic [1:0]            out_lane,
    output logic                  out_last,
    output logic                  busy
);

    state_e                 state_r;
    mode_e                  mode_r;
    logic                   signed_r;
    logic [PASS_CNT_W-1:0]  n_r;
    logic [PASS_CNT_W-1:0]  count_r;
    logic [3:0][ACC_W-1:0]  acc_r;
    logic [1:0]             idx_r;
    logic                   out_valid_r;
    logic [ACC_W-1:0]       out_data_r;
    logic [1:0]             out_lane_r;
    logic                   out_last_r;

    mode_e                  cur_mode_s;
    logic                   cur_signed_s;
    logic                   beat_s;
    logic [3:0][ACC_W-1:0]  lane_s;
    logic [3:0][ACC_W-1:0]  acc_next_s;
    logic [PASS_CNT_W-1:0]  n_in_s;
    logic [PASS_CNT_W-1:0]  count_inc_s;
    logic [2:0]             lanes_s;
    logic [2:0]             idx_inc_s;

    assign psum_ready = (state_r != S_DRAIN);
    assign busy       = (state_r != S_IDLE);
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_lane   = out_lane_r;
    assign out_last   = out_last_r;

    assign beat_s      = psum_valid && (state_r != S_DRAIN);
    assign n_in_s      = (num_passes == '0) ? PASS_CNT_W'(1) : num_passes;
    assign count_inc_s = count_r + PASS_CNT_W'(1);
    assign lanes_s     = lanes_per_mode(cur_mode_s);
    assign idx_inc_s   = {1'b0, idx_r} + 3'd1;

    // Live configuration only matters for the first beat; later beats use the latched copy
    always_comb begin
        if (state_r == S_IDLE) begin
            cur_mode_s   = decode_mode(weight_width);
            cur_signed_s = signed_mode;
        end else begin
            cur_mode_s   = mode_r;
            cur_signed_s = signed_r;
        end
    end

    psum_lane_extract #(.ACC_W(ACC_W)) u_extract (
        .psum_data   (psum_data),
        .mode        (cur_mode_s),
        .signed_mode (cur_signed_s),
        .lanes       (lane_s)
    );

    // First beat loads the accumulators, later beats add (modulo 2^ACC_W)
    always_comb begin
        acc_next_s = lane_s;
        if (state_r == S_ACCUM) begin
            for (int i = 0; i < 4; i++) begin
                acc_next_s[i] = acc_r[i] + lane_s[i];
            end
        end else begin
            acc_next_s = lane_s;
        end
    end

    // Control FSM, accumulators and registered output stream
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            mode_r      <= MODE_8B;
            signed_r    <= 1'b0;
            n_r         <= '0;
            count_r     <= '0;
            acc_r       <= '0;
            idx_r       <= 2'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_lane_r  <= 2'd0;
            out_last_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_ACCUM: begin
                    if (beat_s) begin
                        acc_r <= acc_next_s;
                        if (state_r == S_IDLE) begin
                            mode_r   <= cur_mode_s;
                            signed_r <= signed_mode;
                            n_r      <= n_in_s;
                            count_r  <= PASS_CNT_W'(1);
                            idx_r    <= 2'd0;
                        end else begin
                            count_r  <= count_inc_s;
                        end
                        if ((state_r == S_IDLE && n_in_s == PASS_CNT_W'(1)) ||
                            (state_r == S_ACCUM && count_inc_s == n_r)) begin
                            state_r     <= S_DRAIN;
                            out_valid_r <= 1'b1;
                            out_data_r  <= acc_next_s[0];
                            out_lane_r  <= 2'd0;
                            out_last_r  <= (lanes_s == 3'd1);
                        end else begin
                            state_r     <= S_ACCUM;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (out_last_r) begin
                            state_r     <= S_IDLE;
                            out_valid_r <= 1'b0;
                            out_data_r  <= '0;
                            out_lane_r  <= 2'd0;
                            out_last_r  <= 1'b0;
                            idx_r       <= 2'd0;
                            count_r     <= '0;
                        end else begin
                            idx_r       <= idx_inc_s[1:0];
                            out_data_r  <= acc_r[idx_inc_s[1:0]];
                            out_lane_r  <= idx_inc_s[1:0];
                            out_last_r  <= ((idx_inc_s + 3'd1) == lanes_s);
                        end
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Randomised and directed bench for psum_collector against a lane-arithmetic
// reference model.
module tb_psum_collector;

    localparam int ACC_W = 64;
    localparam int PW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          psum_valid;
    logic          psum_ready;
    logic [51:0]   psum_data;
    logic [3:0]    weight_width;
    logic          signed_mode;
    logic [PW-1:0] num_passes;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [1:0]    out_lane;
    logic          out_last;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_acc [4];

    psum_collector #(.ACC_W(ACC_W), .PASS_CNT_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .weight_width(weight_width), .signed_mode(signed_mode), .num_passes(num_passes),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lanes_of(input logic [3:0] ww);
        return ww[3] ? 1 : (ww[2] ? 2 : 4);
    endfunction

    // Lane i of a packed beat as a 64-bit two's complement (or unsigned) value
    function automatic logic [63:0] lane_val(input logic [51:0] d, input int L, input int i, input bit s);
        int w;
        logic [63:0] v;
        w = 52 / L;
        v = {12'd0, d} >> (i * w);
        v = v & ((64'd1 << w) - 64'd1);
        if (s && v[w-1]) v = v - (64'd1 << w);
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is taken
    task automatic send_beat(input logic [51:0] d, input logic [3:0] ww, input bit sm, input logic [7:0] np);
        int k;
        psum_valid = 1'b1; psum_data = d; weight_width = ww; signed_mode = sm; num_passes = np;
        k = 0;
        while (!psum_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!psum_ready) begin
            chk("beat_timeout", {63'd0, psum_ready}, 64'd1);
            psum_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    task automatic drain(input int L, input bit stall);
        logic [63:0] r;
        for (int i = 0; i < L; i++) begin
            chk("drain_valid", {63'd0, out_valid}, 64'd1);
            if (stall && i == 0) begin
                out_ready = 1'b0;
                psum_valid = 1'b1;
                r = {$urandom, $urandom};
                psum_data = r[51:0];
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_ready", {63'd0, psum_ready}, 64'd0);
                    chk("stall_valid", {63'd0, out_valid}, 64'd1);
                    chk("stall_data", out_data, exp_acc[0]);
                    chk("stall_lane", {62'd0, out_lane}, 64'd0);
                end
                psum_valid = 1'b0;
            end
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'b0;
                @(negedge clk);
                chk("hold_data", out_data, exp_acc[i]);
            end
            out_ready = 1'b1;
            chk("out_data", out_data, exp_acc[i]);
            chk("out_lane", {62'd0, out_lane}, 64'(i));
            chk("out_last", {63'd0, out_last}, (i == L - 1) ? 64'd1 : 64'd0);
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("post_busy", {63'd0, busy}, 64'd0);
        chk("post_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_group(input logic [3:0] ww, input bit sm, input logic [7:0] np,
                             input bit fixed, input logic [51:0] fd, input bit perturb, input bit stall);
        int n, L;
        logic [63:0] r;
        logic [51:0] d;
        n = (np == 8'd0) ? 1 : int'(np);
        L = lanes_of(ww);
        for (int i = 0; i < 4; i++) exp_acc[i] = 64'd0;
        for (int b = 0; b < n; b++) begin
            r = {$urandom, $urandom};
            d = fixed ? fd : r[51:0];
            if (b > 0 && perturb) begin
                r = {$urandom, $urandom};
                send_beat(d, r[3:0], r[4], r[15:8]);
            end else begin
                send_beat(d, ww, sm, np);
            end
            for (int i = 0; i < L; i++) exp_acc[i] = exp_acc[i] + lane_val(d, L, i, sm);
            if (b < n - 1) chk("accum_valid", {63'd0, out_valid}, 64'd0);
        end
        chk("latency_valid", {63'd0, out_valid}, 64'd1);
        drain(L, stall);
    endtask

    initial begin
        logic [63:0] r;
        rst_n = 1'b0; psum_valid = 1'b0; psum_data = 52'd0; weight_width = 4'd0;
        signed_mode = 1'b0; num_passes = 8'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, psum_ready}, 64'd1);
        chk("rst_data", out_data, 64'd0);
        chk("rst_last", {63'd0, out_last}, 64'd0);

        run_group(4'b1000, 1'b1, 8'd1, 1'b1, 52'hF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_group(4'b0100, 1'b0, 8'd2, 1'b1, {26'd3, 26'd5}, 1'b0, 1'b0);
        run_group(4'b0001, 1'b1, 8'd3, 1'b1, {13'd7, 13'h1000, 13'd1, 13'h1FFF}, 1'b0, 1'b0);
        run_group(4'b0000, 1'b1, 8'd2, 1'b0, 52'd0, 1'b0, 1'b1);
        run_group(4'b1000, 1'b0, 8'd0, 1'b1, 52'd42, 1'b0, 1'b0);
        run_group(4'b0100, 1'b1, 8'd4, 1'b0, 52'd0, 1'b1, 1'b0);

        // Reset mid-accumulation drops the partial group
        send_beat(52'd100, 4'b1000, 1'b0, 8'd4);
        send_beat(52'd200, 4'b1000, 1'b0, 8'd4);
        chk("mid_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_busy", {63'd0, busy}, 64'd0);
        chk("rst2_valid", {63'd0, out_valid}, 64'd0);
        run_group(4'b1000, 1'b0, 8'd1, 1'b1, 52'd9, 1'b0, 1'b0);

        for (int g = 0; g < 25; g++) begin
            r = {$urandom, $urandom};
            run_group(r[3:0], r[4], 8'(r[10:8] % 3'd5), 1'b0, 52'd0, 1'b1, r[12] & r[13]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits at the bottom of a column of fusion units and consumes the packed partial sum each unit forwards.
- Unpacks lanes according to the active weight width and sign-extends each lane.
- Accumulates a configurable number of passes per lane.
- Drains the per-lane totals one per cycle over a valid/ready stream to the output buffer.
- It is the reader for the packed psum_fwd lane format written by the fusion units.

Parameters:
- ACC_W, 64, accumulator and output data width; must be at least 52.
- PASS_CNT_W, 8, width of the pass counter and of num_passes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- psum_valid  in  1  a packed psum beat is present.
- psum_ready  out  1  collector accepts a beat this cycle.
- psum_data  in  52  packed psum, same lane layout as psum_fwd.
- weight_width  in  4  width code: 4'b1000 is 8b, 4'b0100 is 4b, 4'b00zz is 2b/1b.
- signed_mode  in  1  lanes are two's complement (s_in | s_weight).
- num_passes  in  PASS_CNT_W  beats per accumulation group; 0 is treated as 1.
- out_valid  out  1  out_data holds a finished lane total.
- out_ready  in  1  downstream accepts.
- out_data  out  ACC_W  accumulated lane total.
- out_lane  out  2  lane index of out_data.
- out_last  out  1  final lane of the group.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset, rst_n low at a clk edge:
  - state goes to IDLE.
  - out_valid, out_last, busy go to 0; out_data and out_lane go to 0.
  - Accumulators and counters are cleared.
  - Any group in progress is dropped, including reset asserted mid-ACCUM or mid-DRAIN.
- Lane layout:
  - 8b mode: 1 lane, lane0 = [51:0].
  - 4b mode: 2 lanes, lane0 = [25:0], lane1 = [51:26].
  - 2b/1b mode: 4 lanes of 13 bits: [12:0], [25:13], [38:26], [51:39].
- Mode decode priority: bit3 selects 8b, else bit2 selects 4b, else 2b.
- Extension: each lane is sign-extended to ACC_W when signed_mode is 1, zero-extended otherwise.
- Accumulation wraps modulo 2^ACC_W; there is no saturation.
- psum_ready = 1 in IDLE and ACCUM, 0 in DRAIN. It is decoded from registered state only, with no combinational path from out_ready.
- A beat transfers when psum_valid and psum_ready are both high.
- IDLE:
  - On a beat: latch mode, signed_mode and N = max(num_passes, 1).
  - Load each acc[i] with extended lane i; set count = 1.
  - Go to DRAIN if N == 1, else to ACCUM.
- ACCUM:
  - On a beat: acc[i] += extended lane i; count++.
  - When the incremented count equals N, go to DRAIN.
  - Changes to weight_width, signed_mode or num_passes while in ACCUM are ignored; latched values rule.
- DRAIN:
  - out_valid = 1; out_data = acc[idx]; out_lane = idx; out_last = (idx == lanes-1). idx starts at 0.
  - On an out_ready handshake, idx++.
  - Handshake with out_last = 1: next cycle state is IDLE and out_valid = 0.
  - While out_ready is low, all out_* signals hold stable.
- Latency:
  - The final beat accepted at edge t gives out_valid = 1 after edge t, i.e. visible in cycle t+1.
  - A group of L lanes drains in L cycles with out_ready held high.
  - The next group's first beat is accepted no earlier than the cycle after the last drain handshake.
- psum_valid during DRAIN is not accepted. The beat stays pending upstream; it is not lost.
- Unused accumulators in narrower modes are not driven to the output.

Decomposition:
- Shared package fusion_pkg holds:
  - mode enum {MODE_8B, MODE_4B, MODE_2B}.
  - PSUM_W = 52 and LANE_W_8B/4B/2B = 52/26/13.
  - a lanes-per-mode function returning 1, 2 or 4.
  - state enum {S_IDLE, S_ACCUM, S_DRAIN}.
- One combinational sub-module, psum_lane_extract:
  - inputs: psum_data, mode, signed_mode.
  - outputs: four ACC_W-wide extended lanes; lanes unused by the mode are zero.
- Control FSM, counters and accumulators stay in psum_collector.

Test Plan:
- 8b, signed, num_passes = 1, psum_data = 52'hF_FFFF_FFFF_FFFF -> one output: out_data = 64'hFFFF_FFFF_FFFF_FFFF, out_lane = 0, out_last = 1, in cycle t+1.
- 4b, unsigned, num_passes = 2, two beats with lane1 = 3 and lane0 = 5 -> outputs 10 (lane0, last = 0) then 6 (lane1, last = 1), then busy = 0.
- 2b, signed, num_passes = 3, each beat lanes {7, 13'h1000, 1, 13'h1FFF} (lane3..lane0) -> out_data = -3, 3, -12288, 21 for lanes 0..3.
- In DRAIN, out_ready low for 5 cycles with psum_valid high -> out_* stable, psum_ready = 0, no accumulator change; drain completes after out_ready rises.
- num_passes = 0 with one beat of 8b value 42 -> out_data = 42 immediately; weight_width toggled mid-ACCUM (num_passes = 4) -> lane count unchanged.
- rst_n low for one cycle mid-ACCUM after 2 of 4 beats -> IDLE, busy = 0, out_valid = 0; a fresh group of one beat of value 9 outputs 9, not a sum with earlier beats.
